// File: rtl/clock_set_controller.sv
// Run/set mode sequencer for the clock: base tick, field increment strobes, blink.
// Optional AUTO_EXIT_EN: leave a set mode after IDLE_TIMEOUT cycles without buttons.
module clock_set_controller #(
   parameter int unsigned TICK_DIV     = 100000000,
   parameter int unsigned HOLD_START   = 300000000,
   parameter int unsigned HOLD_REPEAT  = 50000000,
   parameter int unsigned BLINK_DIV    = 25000000,
   parameter int unsigned IDLE_TIMEOUT = 1000000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       BTN_mode,
   input  logic       BTN_up,
   output logic       tick,
   output logic       inc_hour,
   output logic       inc_min,
   output logic       inc_sec,
   output logic [1:0] field_sel,
   output logic       blink,
   output logic       running
);

   localparam int unsigned TW     = $clog2(TICK_DIV) + 1;
   localparam int unsigned HOLDMX = (HOLD_START > HOLD_REPEAT) ? HOLD_START : HOLD_REPEAT;
   localparam int unsigned HW     = $clog2(HOLDMX) + 1;
   localparam int unsigned BW     = $clog2(BLINK_DIV) + 1;

   if (TICK_DIV < 2 || HOLD_START < 1 || HOLD_REPEAT < 1 || BLINK_DIV < 1 || IDLE_TIMEOUT < 1)
   begin : g_param_check
      $error("clock_set_controller: divider parameters out of range");
   end

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      SET_HOUR = 2'd1,
      SET_MIN  = 2'd2,
      SET_SEC  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            mode_q, up_q;
   logic [TW-1:0]   presc_q, presc_d;
   logic [HW-1:0]   hold_q, hold_d, hold_lim;
   logic            rep_q, rep_d;
   logic            arm_q, arm_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic            blink_q, blink_d;
   logic            inc_hour_q, inc_hour_d;
   logic            inc_min_q, inc_min_d;
   logic            inc_sec_q, inc_sec_d;
   logic            in_set, mode_edge, up_edge, strobe, timeout;
`ifdef AUTO_EXIT_EN
   localparam int unsigned IW = $clog2(IDLE_TIMEOUT) + 1;
   logic [IW-1:0]   idle_q, idle_d;
`endif

   always_comb begin
      in_set    = (state_q != RUN);
      mode_edge = BTN_mode & ~mode_q;
      up_edge   = BTN_up & ~up_q;
      tick      = ~in_set && (presc_q >= TW'(TICK_DIV - 1));

      timeout = 1'b0;
`ifdef AUTO_EXIT_EN
      idle_d = '0;
      if (in_set && !BTN_mode && !BTN_up) begin
         if (idle_q >= IW'(IDLE_TIMEOUT - 1)) timeout = 1'b1;
         else                                  idle_d  = idle_q + 1'b1;
      end
`endif

      state_d = state_q;
      if (mode_edge) begin
         unique case (state_q)
            RUN:      state_d = SET_HOUR;
            SET_HOUR: state_d = SET_MIN;
            SET_MIN:  state_d = SET_SEC;
            SET_SEC:  state_d = RUN;
         endcase
      end else if (timeout) begin
         state_d = RUN;
      end

      presc_d = (in_set || tick) ? '0 : presc_q + 1'b1;

      // Hold counting needs an up edge seen in this field; a mode edge disarms it.
      strobe   = 1'b0;
      hold_d   = '0;
      rep_d    = 1'b0;
      arm_d    = 1'b0;
      hold_lim = rep_q ? HW'(HOLD_REPEAT - 1) : HW'(HOLD_START - 1);
      if (in_set && BTN_up && !mode_edge) begin
         if (up_edge) begin
            strobe = 1'b1;
            arm_d  = 1'b1;
         end else if (arm_q) begin
            arm_d = 1'b1;
            if (hold_q >= hold_lim) begin
               strobe = 1'b1;
               rep_d  = 1'b1;
            end else begin
               hold_d = hold_q + 1'b1;
               rep_d  = rep_q;
            end
         end
      end

      inc_hour_d = strobe && (state_q == SET_HOUR);
      inc_min_d  = strobe && (state_q == SET_MIN);
      inc_sec_d  = strobe && (state_q == SET_SEC);

      bcnt_d  = '0;
      blink_d = 1'b0;
      if (state_d != state_q) begin
         blink_d = (state_d != RUN);
      end else if (in_set) begin
         if (bcnt_q >= BW'(BLINK_DIV - 1)) begin
            blink_d = ~blink_q;
         end else begin
            bcnt_d  = bcnt_q + 1'b1;
            blink_d = blink_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         mode_q     <= 1'b0;
         up_q       <= 1'b0;
         presc_q    <= '0;
         hold_q     <= '0;
         rep_q      <= 1'b0;
         arm_q      <= 1'b0;
         bcnt_q     <= '0;
         blink_q    <= 1'b0;
         inc_hour_q <= 1'b0;
         inc_min_q  <= 1'b0;
         inc_sec_q  <= 1'b0;
`ifdef AUTO_EXIT_EN
         idle_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         mode_q     <= BTN_mode;
         up_q       <= BTN_up;
         presc_q    <= presc_d;
         hold_q     <= hold_d;
         rep_q      <= rep_d;
         arm_q      <= arm_d;
         bcnt_q     <= bcnt_d;
         blink_q    <= blink_d;
         inc_hour_q <= inc_hour_d;
         inc_min_q  <= inc_min_d;
         inc_sec_q  <= inc_sec_d;
`ifdef AUTO_EXIT_EN
         idle_q     <= idle_d;
`endif
      end
   end

   assign field_sel = state_q;
   assign running   = (state_q == RUN);
   assign blink     = blink_q;
   assign inc_hour  = inc_hour_q;
   assign inc_min   = inc_min_q;
   assign inc_sec   = inc_sec_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: per-cycle behavioural model plus literal checks.
module tb_clock_set_controller;

   localparam int TD = 10;
   localparam int HS = 20;
   localparam int HR = 5;
   localparam int BD = 4;
   localparam int IT = 50;

   logic       clk = 1'b0;
   logic       rst, BTN_mode, BTN_up;
   logic       tick, inc_hour, inc_min, inc_sec, blink, running;
   logic [1:0] field_sel;

   int total = 0;
   int bad   = 0;

   clock_set_controller #(
      .TICK_DIV(TD), .HOLD_START(HS), .HOLD_REPEAT(HR), .BLINK_DIV(BD), .IDLE_TIMEOUT(IT)
   ) dut (
      .clk(clk), .rst(rst), .BTN_mode(BTN_mode), .BTN_up(BTN_up),
      .tick(tick), .inc_hour(inc_hour), .inc_min(inc_min), .inc_sec(inc_sec),
      .field_sel(field_sel), .blink(blink), .running(running)
   );

   always #5 clk = ~clk;

   int n = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, n, got, want);
      end
   endtask

   // Model: field = count of mode edges mod 4; tick/blink are phases measured from
   // entry time; inc strobes fall at fixed offsets from the up-button rise.
   bit mv = 0;
   int f, run_start, set_start, rise, last_act, o;
   bit armed, ph, pm_, ps, pmode, pup, me, ue, tmo;
   bit nph, npm, nps;

   always @(negedge clk) begin
      if (rst) begin
         mv = 1; f = 0; run_start = n + 1; set_start = 0; last_act = n;
         armed = 0; ph = 0; pm_ = 0; ps = 0; pmode = 0; pup = 0;
      end else if (mv) begin
         check("m_tick", 64'(tick), 64'((f == 0) && ((n - run_start) % TD == TD - 1)));
         check("m_blink", 64'(blink), 64'((f != 0) && (((n - set_start) / BD) % 2 == 0)));
         check("m_running", 64'(running), 64'(f == 0));
         check("m_field", 64'(field_sel), 64'(f));
         check("m_inc_hour", 64'(inc_hour), 64'(ph));
         check("m_inc_min", 64'(inc_min), 64'(pm_));
         check("m_inc_sec", 64'(inc_sec), 64'(ps));

         me = BTN_mode && !pmode;
         ue = BTN_up && !pup;
         nph = 0; npm = 0; nps = 0;
         if (f != 0 && BTN_up && !me) begin
            if (ue) begin armed = 1; rise = n; end
            if (armed) begin
               o = n - rise;
               if (o == 0 || (o >= HS && (o - HS) % HR == 0)) begin
                  nph = (f == 1); npm = (f == 2); nps = (f == 3);
               end
            end
         end else begin
            armed = 0;
         end
         ph = nph; pm_ = npm; ps = nps;

         tmo = 0;
`ifdef AUTO_EXIT_EN
         if (BTN_mode || BTN_up) last_act = n;
         tmo = (f != 0) && !BTN_mode && !BTN_up &&
               (n - ((set_start > last_act + 1) ? set_start : last_act + 1) == IT - 1);
`endif
         if (me) begin
            f = (f + 1) % 4;
            if (f == 0) run_start = n + 1;
            else        set_start = n + 1;
         end else if (tmo) begin
            f = 0;
            run_start = n + 1;
         end
         pmode = BTN_mode;
         pup   = BTN_up;
      end
      n++;
   end

   logic s_tick, s_hour, s_min, s_sec, s_blink, s_run;
   logic [1:0] s_field;

   task automatic step(input logic m, input logic u);
      BTN_mode = m;
      BTN_up   = u;
      @(negedge clk);
      s_tick = tick; s_hour = inc_hour; s_min = inc_min; s_sec = inc_sec;
      s_blink = blink; s_run = running; s_field = field_sel;
      @(posedge clk);
      #1;
   endtask

   logic [63:0] mask;
   int cnt, ch, cm, cs, first;
   int fields[4];

   initial begin
      rst = 1'b1; BTN_mode = 1'b0; BTN_up = 1'b0;
      step(0, 0);
      step(0, 0);
      rst = 1'b0;

      // Reset state, then free-running ticks.
      mask = '0;
      for (int i = 0; i < 35; i++) begin
         step(0, 0);
         if (i == 0) begin
            check("rst_running", 64'(s_run), 64'd1);
            check("rst_field", 64'(s_field), 64'd0);
            check("rst_blink", 64'(s_blink), 64'd0);
            check("rst_inc", 64'({s_hour, s_min, s_sec}), 64'd0);
         end
         if (s_tick) mask |= 64'd1 << i;
      end
      check("tick_positions", mask, 64'h2008_0200);

      // Mode cycle through all fields, no ticks outside RUN.
      cnt = 0;
      for (int k = 0; k < 3; k++) begin
         step(1, 0);
         if (s_tick && s_field != 2'd0) cnt++;
         for (int j = 0; j < 9; j++) begin
            step(0, 0);
            if (j == 0) fields[k] = int'(s_field);
            if (s_tick && s_field != 2'd0) cnt++;
         end
      end
      step(1, 0);
      first = -1;
      for (int j = 1; j <= 15; j++) begin
         step(0, 0);
         if (j == 1) fields[3] = int'(s_field);
         if (s_tick && first < 0) first = j;
      end
      check("field_hour", 64'(fields[0]), 64'd1);
      check("field_min", 64'(fields[1]), 64'd2);
      check("field_sec", 64'(fields[2]), 64'd3);
      check("field_run", 64'(fields[3]), 64'd0);
      check("no_tick_in_set", 64'(cnt), 64'd0);
      check("first_tick_after_run", 64'(first), 64'd10);

      // Single press in SET_MIN.
      step(1, 0); step(0, 0); step(1, 0); step(0, 0);
      mask = '0; ch = 0; cs = 0;
      step(0, 1);
      if (s_min) mask |= 64'd1;
      for (int j = 1; j < 5; j++) begin
         step(0, 0);
         if (s_min) mask |= 64'd1 << j;
         ch += int'(s_hour); cs += int'(s_sec);
      end
      check("min_single_pulse", mask, 64'h2);
      check("min_press_hour", 64'(ch), 64'd0);
      check("min_press_sec", 64'(cs), 64'd0);

      // Into SET_HOUR: blink phase, then hold auto-repeat.
      step(1, 0); step(0, 0); step(1, 0); step(0, 0); step(1, 0);
      mask = '0;
      for (int j = 0; j < 12; j++) begin
         step(0, 0);
         if (s_blink) mask |= 64'd1 << j;
      end
      check("blink_pattern", mask, 64'hF0F);
      mask = '0; cm = 0; cs = 0;
      for (int j = 0; j <= 50; j++) begin
         step(0, (j <= 40) ? 1'b1 : 1'b0);
         if (s_hour) mask |= 64'd1 << j;
         cm += int'(s_min); cs += int'(s_sec);
      end
      check("hold_repeat_offsets", mask, 64'h210_8420_0002);
      check("hold_other_fields", 64'(cm + cs), 64'd0);

      // Mode and up rise together in SET_SEC: exit wins.
      step(1, 0); step(0, 0); step(1, 0); step(0, 0);
      cnt = 0;
      step(1, 1);
      cnt += int'(s_sec);
      for (int j = 0; j < 3; j++) begin
         step(0, 1);
         cnt += int'(s_sec) + int'(s_hour) + int'(s_min);
         if (j == 0) check("simul_exit_running", 64'(s_run), 64'd1);
      end
      step(0, 0);
      check("simul_no_inc", 64'(cnt), 64'd0);

      // Held up across a field change needs a fresh edge.
      step(1, 0); step(0, 0);
      cnt = 0;
      step(1, 1);
      for (int j = 0; j < 26; j++) begin
         step(0, 1);
         cnt += int'(s_hour) + int'(s_min) + int'(s_sec);
      end
      check("carry_hold_field", 64'(s_field), 64'd2);
      check("carry_hold_no_inc", 64'(cnt), 64'd0);
      step(0, 0);

      // Reset while a repeat strobe is due.
      step(0, 1);
      for (int j = 1; j < 20; j++) step(0, 1);
      rst = 1'b1;
      step(0, 1);
      rst = 1'b0;
      step(0, 1);
      check("rst_mid_hold_outputs",
            64'({s_tick, s_hour, s_min, s_sec, s_blink, s_run, s_field}), 64'b0000_0100);
      step(0, 0);

      // Idle in SET_MIN: auto-exit only when the option is built in.
      step(1, 0); step(0, 0); step(1, 0);
      first = -1;
      for (int j = 0; j <= 60; j++) begin
         step(0, 0);
         if (s_run && first < 0) first = j;
      end
`ifdef AUTO_EXIT_EN
      check("auto_exit_cycle", 64'(first), 64'd50);
`else
      check("no_auto_exit", 64'(first), 64'hFFFF_FFFF_FFFF_FFFF);
`endif
      step(0, 0);
      step(0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- Sequences the three time-field counters (hours, minutes, seconds) of the digital clock.
- Generates the 1 Hz base tick and owns the run/set mode FSM.
- In set modes it routes up-button presses and auto-repeat to exactly one field, freezes timekeeping and drives a display blink flag for the edited field.
- Sits between the debounced button inputs and the field counters' trigger/increment inputs.

Parameters:
TICK_DIV, 100000000, clk cycles per base tick (1 s at 100 MHz)
HOLD_START, 300000000, cycles BTN_up held in a set mode before auto-repeat starts
HOLD_REPEAT, 50000000, cycles between auto-repeat increments
BLINK_DIV, 25000000, cycles per blink half-period
IDLE_TIMEOUT, 1000000000, cycles without button activity before auto-exit (only with AUTO_EXIT_EN)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
BTN_mode  input  1  debounced mode button, level
BTN_up  input  1  debounced increment button, level
tick  output  1  one-cycle base-tick pulse to seconds counter trigger; RUN only
inc_hour  output  1  one-cycle increment strobe, hour field
inc_min  output  1  one-cycle increment strobe, minute field
inc_sec  output  1  one-cycle increment strobe, second field
field_sel  output  2  0=none(RUN), 1=hour, 2=min, 3=sec
blink  output  1  display blanking phase for selected field; 0 in RUN
running  output  1  1 in RUN

Behaviour:
- One clock (clk), reset synchronous and active-high (rst). Reset: state=RUN, all counters 0, tick=inc_*=blink=0, field_sel=0, running=1; the button edge registers load 0.
- Edges: BTN_mode/BTN_up registered each cycle. A rising edge is current=1 and registered=0. A button already held at reset release gives one edge on the first cycle.
- FSM RUN -> SET_HOUR -> SET_MIN -> SET_SEC -> RUN. The transition occurs on each BTN_mode rising edge, effective next cycle. No other transitions exist except reset and the optional auto-exit.
- Prescaler 0..TICK_DIV-1, counts only in RUN. tick=1 combinationally when prescaler==TICK_DIV-1 and state==RUN; the prescaler then wraps to 0. Tick period is exactly TICK_DIV cycles.
- Leaving RUN clears the prescaler to 0. Re-entering RUN gives the first tick TICK_DIV cycles after entry.
- Set modes:
  - BTN_up rising edge -> inc_<field> registered, asserted 1 cycle later for 1 cycle.
  - Hold counter clears on that edge and counts while BTN_up=1.
  - At HOLD_START-1 it emits a strobe and reloads 0, entering repeat phase. In repeat phase a strobe fires every HOLD_REPEAT cycles.
  - BTN_up=0 clears the counter and phase.
- At most one inc_* high in any cycle. inc_* never asserted in RUN, and BTN_up is ignored in RUN.
- Simultaneous BTN_mode edge and BTN_up edge/hold strobe: mode wins, no inc strobe, hold counter cleared. The next field needs a fresh BTN_up edge.
- blink: counter 0..BLINK_DIV-1 toggles blink at wrap in set modes. On entry to any set mode, blink=1 and the counter is 0. In RUN blink=0 and the counter is held at 0.
- field_sel and running decode the state registers directly (no extra latency).
- Counter widths: $clog2(param)+1 bits, compare with >= so no overflow.
- Reset mid-hold or mid-set: immediate return to RUN with all strobes 0 next cycle.

Optional Feature:
AUTO_EXIT_EN
- Defined:
  - An idle counter runs in set modes and clears on any BTN_mode or BTN_up level high.
  - Reaching IDLE_TIMEOUT-1 forces state=RUN next cycle, with prescaler and blink cleared as for a normal exit.
  - If the timeout coincides with a BTN_mode edge, the button edge wins.
- Undefined: no idle counter, and set modes persist indefinitely.

Test Plan:
- Test parameters: TICK_DIV=10, HOLD_START=20, HOLD_REPEAT=5, BLINK_DIV=4, IDLE_TIMEOUT=50.
- Reset, idle 35 cycles -> tick pulses at cycles 9, 19, 29; running=1, field_sel=0, no inc_*.
- Four BTN_mode pulses spaced 10 cycles -> field_sel 1, 2, 3, 0. No tick while field_sel!=0. First tick exactly 10 cycles after returning to RUN.
- SET_MIN, BTN_up high 1 cycle -> single inc_min pulse one cycle later; inc_hour=inc_sec=0.
- SET_HOUR, BTN_up held 40 cycles -> 1 initial pulse, repeat at +20, then +25, +30, +35, +40 (6 pulses); 0 after release.
- BTN_mode and BTN_up rise same cycle in SET_SEC -> state RUN, no inc_sec; in SET_HOUR, blink toggles every 4 cycles starting at 1.
- AUTO_EXIT_EN: enter SET_MIN, no buttons 50 cycles -> running=1 at cycle 50; rst asserted mid-hold -> all outputs at reset values next cycle.
